// File: rtl/iobufphy_pkg.sv
// Shared state encoding and pull-up resolution for the IO header buffer model.
// IOBUFPHY_PULLUP_EN: header has an external pull-up, so z/x read as 1.
package iobufphy_pkg;

  typedef enum logic [1:0] {
    S_IN     = 2'd0,
    S_TO_OUT = 2'd1,
    S_OUT    = 2'd2,
    S_TO_IN  = 2'd3
  } chan_state_e;

  function automatic logic pullup_res(input logic v);
`ifdef IOBUFPHY_PULLUP_EN
    return (v === 1'b0) ? 1'b0 : 1'b1;
`else
    return v;
`endif
  endfunction

endpackage

// File: rtl/iobufphy_if.sv
// Control/status bundle between harness stimulus (master) and the buffer bank (slave).
// The tristate pins bufio and iopin_state stay plain ports on the bank.
interface iobufphy_if #(
  parameter int CHANNELS = 8,
  parameter int CNT_W    = 8
);
  logic [CHANNELS-1:0]       bufdir;
  logic [CHANNELS-1:0]       bufod;
  logic [CHANNELS-1:0]       fpga_oe;
  logic [CHANNELS-1:0]       iopin_input;
  logic                      contention_clear;
  logic [CHANNELS-1:0]       iopin_contention;
  logic [CHANNELS-1:0]       dir_settled;
  logic [CHANNELS*CNT_W-1:0] contention_count;

  modport master (
    output bufdir, bufod, fpga_oe, iopin_input, contention_clear,
    input  iopin_contention, dir_settled, contention_count
  );

  modport slave (
    input  bufdir, bufod, fpga_oe, iopin_input, contention_clear,
    output iopin_contention, dir_settled, contention_count
  );
endinterface

// File: rtl/iobufphy_chan.sv
// One buffer channel: direction FSM with turnaround timer, header->FPGA delay line,
// header level model and contention tracking. IOBUFPHY_PULLUP_EN resolves z/x to 1.
module iobufphy_chan
  import iobufphy_pkg::*;
#(
  parameter int TURN_CYC = 2,
  parameter int PROP_CYC = 1,
  parameter int CNT_W    = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             bufdir,
  input  logic             bufod,
  input  logic             fpga_oe,
  input  logic             iopin_input,
  input  logic             contention_clear,
  input  logic             bufio_in,
  output logic             bufio_out,
  output logic             bufio_oe,
  output logic             state_val,
  output logic             state_oe,
  output logic             iopin_contention,
  output logic             dir_settled,
  output logic [CNT_W-1:0] contention_count
);

  localparam int              TW    = (TURN_CYC > 0) ? $clog2(TURN_CYC + 1) : 1;
  localparam logic [TW-1:0]   TLOAD = TW'(TURN_CYC);
  localparam logic [TW-1:0]   T_ONE = TW'(1);
  localparam logic [CNT_W-1:0] CMAX = '1;

  chan_state_e         st, st_nx;
  logic [TW-1:0]       tcnt, tcnt_nx;
  logic [PROP_CYC-1:0] pipe;
  logic                pin, ev;
  logic                sv_nx, so_nx, ds_nx;

  assign pin       = pullup_res(iopin_input);
  assign ev        = fpga_oe && (st == S_IN);
  assign bufio_out = pipe[PROP_CYC-1];
  assign bufio_oe  = (st == S_IN);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      st   <= S_IN;
      tcnt <= '0;
    end else begin
      st   <= st_nx;
      tcnt <= tcnt_nx;
    end
  end

  // Turnaround occupies exactly TURN_CYC cycles: leave when the count is at its last tick.
  always_comb begin
    st_nx   = st;
    tcnt_nx = tcnt;
    sv_nx   = 1'b0;
    so_nx   = 1'b0;
    ds_nx   = 1'b0;
    unique case (st)
      S_IN: begin
        so_nx = 1'b1;
        sv_nx = bufod ? pin : 1'b0;
        ds_nx = !bufdir;
        if (bufdir) begin
          st_nx   = (TURN_CYC == 0) ? S_OUT : S_TO_OUT;
          tcnt_nx = TLOAD;
        end
      end
      S_TO_OUT: begin
        if (!bufdir) begin
          st_nx   = S_TO_IN;
          tcnt_nx = TLOAD;
        end else if (tcnt <= T_ONE) st_nx = S_OUT;
        else tcnt_nx = tcnt - T_ONE;
      end
      S_OUT: begin
        sv_nx = pullup_res(bufio_in);
`ifdef IOBUFPHY_PULLUP_EN
        so_nx = 1'b1;
`else
        so_nx = fpga_oe;
`endif
        ds_nx = bufdir;
        if (!bufdir) begin
          st_nx   = (TURN_CYC == 0) ? S_IN : S_TO_IN;
          tcnt_nx = TLOAD;
        end
      end
      S_TO_IN: begin
        if (bufdir) begin
          st_nx   = S_TO_OUT;
          tcnt_nx = TLOAD;
        end else if (tcnt <= T_ONE) st_nx = S_IN;
        else tcnt_nx = tcnt - T_ONE;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pipe <= '0;
    end else begin
      pipe[0] <= pin;
      for (int k = 1; k < PROP_CYC; k++) pipe[k] <= pipe[k-1];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_val        <= 1'b0;
      state_oe         <= 1'b0;
      dir_settled      <= 1'b1;
      iopin_contention <= 1'b0;
      contention_count <= '0;
    end else begin
      state_val   <= sv_nx;
      state_oe    <= so_nx;
      dir_settled <= ds_nx;
      // A clear still records an event landing in the same cycle.
      if (contention_clear) begin
        iopin_contention <= ev;
        contention_count <= CNT_W'(ev);
      end else if (ev) begin
        iopin_contention <= 1'b1;
        if (contention_count != CMAX) contention_count <= contention_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/iobufphy_bank.sv
// N-channel IO header buffer model; channels are independent instances of iobufphy_chan.
// Honours IOBUFPHY_PULLUP_EN through the channel and package.
module iobufphy_bank
  import iobufphy_pkg::*;
#(
  parameter int CHANNELS = 8,
  parameter int TURN_CYC = 2,
  parameter int PROP_CYC = 1,
  parameter int CNT_W    = 8
) (
  input  logic                clock,
  input  logic                reset,
  iobufphy_if.slave           bus,
  inout  wire  [CHANNELS-1:0] bufio,
  output wire  [CHANNELS-1:0] iopin_state
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    logic b_out, b_oe, s_val, s_oe;

    iobufphy_chan #(
      .TURN_CYC (TURN_CYC),
      .PROP_CYC (PROP_CYC),
      .CNT_W    (CNT_W)
    ) u_chan (
      .clock            (clock),
      .reset            (reset),
      .bufdir           (bus.bufdir[i]),
      .bufod            (bus.bufod[i]),
      .fpga_oe          (bus.fpga_oe[i]),
      .iopin_input      (bus.iopin_input[i]),
      .contention_clear (bus.contention_clear),
      .bufio_in         (bufio[i]),
      .bufio_out        (b_out),
      .bufio_oe         (b_oe),
      .state_val        (s_val),
      .state_oe         (s_oe),
      .iopin_contention (bus.iopin_contention[i]),
      .dir_settled      (bus.dir_settled[i]),
      .contention_count (bus.contention_count[i*CNT_W +: CNT_W])
    );

    assign bufio[i]       = b_oe ? b_out : 1'bz;
    assign iopin_state[i] = s_oe ? s_val : 1'bz;
  end

endmodule

// File: tb/tb_iobufphy_bank.sv
// Randomized bench for iobufphy_bank against a direction/turnaround reference model.
module tb_iobufphy_bank;
  localparam int CH   = 8;
  localparam int TURN = 2;
  localparam int PROP = 2;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;
`ifdef IOBUFPHY_PULLUP_EN
  localparam bit PU = 1'b1;
`else
  localparam bit PU = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  iobufphy_if #(.CHANNELS(CH), .CNT_W(CW)) bus();
  wire  [CH-1:0] bufio;
  wire  [CH-1:0] iopin_state;
  logic [CH-1:0] drv;

  for (genvar g = 0; g < CH; g++) begin : g_fpga
    assign bufio[g] = bus.fpga_oe[g] ? drv[g] : 1'bz;
  end

  iobufphy_bank #(
    .CHANNELS (CH),
    .TURN_CYC (TURN),
    .PROP_CYC (PROP),
    .CNT_W    (CW)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .bus         (bus),
    .bufio       (bufio),
    .iopin_state (iopin_state)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", tag, act, exp);
    end
  endtask

  // Model: target direction plus cycles remaining until it is settled.
  int   m_dir [CH];
  int   m_rem [CH];
  int   m_cnt [CH];
  bit   m_flag[CH];
  logic m_pipe[CH][$];
  logic [CH-1:0] e_state, e_set;

  function automatic logic res(input logic v);
    if (PU) return (v === 1'b0) ? 1'b0 : 1'b1;
    return v;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < CH; i++) begin
      m_dir[i] = 0; m_rem[i] = 0; m_cnt[i] = 0; m_flag[i] = 1'b0;
      m_pipe[i].delete();
      repeat (PROP) m_pipe[i].push_back(1'b0);
    end
    e_state = 'z;
    e_set   = '1;
  endfunction

  function automatic void model_edge();
    for (int i = 0; i < CH; i++) begin
      bit   in_ok, out_ok, ev;
      logic pin;
      in_ok  = (m_dir[i] == 0) && (m_rem[i] == 0);
      out_ok = (m_dir[i] == 1) && (m_rem[i] == 0);
      ev     = bus.fpga_oe[i] && in_ok;
      pin    = res(bus.iopin_input[i]);
      if (in_ok)       e_state[i] = bus.bufod[i] ? pin : 1'b0;
      else if (out_ok) e_state[i] = bus.fpga_oe[i] ? res(drv[i]) : (PU ? 1'b1 : 1'bz);
      else             e_state[i] = 1'bz;
      e_set[i] = (in_ok && !bus.bufdir[i]) || (out_ok && bus.bufdir[i]);
      if (bus.contention_clear) begin
        m_flag[i] = ev;
        m_cnt[i]  = ev ? 1 : 0;
      end else if (ev) begin
        m_flag[i] = 1'b1;
        if (m_cnt[i] < CMAX) m_cnt[i]++;
      end
      m_pipe[i].push_back(pin);
      void'(m_pipe[i].pop_front());
      if (int'(bus.bufdir[i]) != m_dir[i]) begin
        m_dir[i] = int'(bus.bufdir[i]);
        m_rem[i] = TURN;
      end else if (m_rem[i] > 0) m_rem[i]--;
    end
  endfunction

  task automatic check_all();
    logic [31:0] ecnt;
    logic [CH-1:0] eflag;
    ecnt = '0;
    for (int i = 0; i < CH; i++) begin
      ecnt[i*CW +: CW] = CW'(m_cnt[i]);
      eflag[i] = m_flag[i];
    end
    chk("iopin_state", 32'(iopin_state), 32'(e_state));
    chk("dir_settled", 32'(bus.dir_settled), 32'(e_set));
    chk("contention", 32'(bus.iopin_contention), 32'(eflag));
    chk("count", bus.contention_count, ecnt);
    for (int i = 0; i < CH; i++)
      if (!bus.fpga_oe[i])
        chk("bufio", 32'(bufio[i]),
            32'(((m_dir[i] == 0) && (m_rem[i] == 0)) ? m_pipe[i][0] : 1'bz));
  endtask

  task automatic step();
    @(posedge clock);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic do_reset();
    @(negedge clock);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_all();
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    bus.bufdir = '0; bus.bufod = '1; bus.fpga_oe = '0;
    bus.iopin_input = '1; bus.contention_clear = 1'b0; drv = '0;
    model_reset();
    #12;
    check_all();
    @(negedge clock);
    reset = 1'b0;

    // input path: header level reaches bufio after PROP clocks
    repeat (3) step();
    chk("t1_bufio", 32'(bufio[0]), 32'(1'b1));
    chk("t1_state", 32'(iopin_state[0]), 32'(1'b1));

    // turnaround into output, then FPGA drives 0
    bus.bufdir[0] = 1'b1;
    repeat (4) step();
    bus.fpga_oe[0] = 1'b1; drv[0] = 1'b0;
    step();
    chk("t2_state", 32'(iopin_state[0]), 32'(1'b0));

    // contention on channel 1, clear coinciding with an event, then saturation
    bus.fpga_oe[1] = 1'b1; drv[1] = 1'b1;
    repeat (5) step();
    chk("t3_count5", 32'(bus.contention_count[CW +: CW]), 32'd5);
    chk("t3_flag", 32'(bus.iopin_contention[1]), 32'd1);
    bus.contention_clear = 1'b1;
    step();
    bus.contention_clear = 1'b0;
    chk("t3_count1", 32'(bus.contention_count[CW +: CW]), 32'd1);
    repeat (20) step();
    chk("t4_sat", 32'(bus.contention_count[CW +: CW]), 32'(CMAX));
    bus.fpga_oe[1] = 1'b0;

    // reverse mid-turnaround, then reset while turning back
    bus.bufdir[2] = 1'b1;
    step();
    bus.bufdir[2] = 1'b0;
    step();
    do_reset();
    chk("t5_count", bus.contention_count, 32'd0);

    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < CH; i++)
        if ($urandom_range(3) == 0) bus.bufdir[i] = ~bus.bufdir[i];
      bus.bufod            = CH'($urandom);
      bus.fpga_oe          = CH'($urandom & $urandom);
      bus.iopin_input      = CH'($urandom);
      drv                  = CH'($urandom);
      bus.contention_clear = ($urandom_range(15) == 0);
      step();
      if (n == 200) do_reset();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
